// File: rtl/truth_table_scanner_pkg.sv
// Shared constants and FSM state type for the 5-input truth table scanner.
package truth_table_scanner_pkg;

    localparam int NUM_VECTORS = 32;
    localparam int VEC_W       = 5;
    localparam int CNT_W       = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/truth_table_scanner_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the last cycle of each dwell.
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    logic [7:0] count;

    assign terminal = (count == 8'(DWELL - 1));

    // Wraps back to zero on the terminal cycle so consecutive dwells line up without a gap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= terminal ? '0 : count + 8'd1;
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks a 5-bit vector through all 32 values, holding each for DWELL cycles and capturing f_in.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f_in,
    output logic        V,
    output logic        W,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic        busy,
    output logic        done,
    output logic [31:0] truth_table,
    output logic [5:0]  ones_count
);

    state_t           state;
    state_t           state_next;
    logic [VEC_W-1:0] vec;
    logic             accept;
    logic             sample;
    logic             last_vec;
    logic             terminal;

    assign accept   = ((state == IDLE) || (state == DONE)) && start;
    assign sample   = (state == DRIVE) && terminal;
    assign last_vec = (vec == VEC_W'(NUM_VECTORS - 1));

    dwell_counter #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (state == DRIVE),
        .terminal(terminal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (sample && last_vec) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Results are cleared on an accepted start so unsampled bits read zero throughout a scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec         <= '0;
            truth_table <= '0;
            ones_count  <= '0;
        end else if (accept) begin
            vec         <= '0;
            truth_table <= '0;
            ones_count  <= '0;
        end else if (sample) begin
            truth_table[vec] <= f_in;
            ones_count       <= ones_count + CNT_W'(f_in);
            if (!last_vec) begin
                vec <= vec + VEC_W'(1);
            end
        end
    end

    assign {V, W, X, Y, Z} = vec;
    assign busy            = (state == DRIVE);
    assign done            = (state == DONE);

endmodule
